speed_tick_decoder: RTL and testbench
=====================================

// Module: speed_tick_decoder
// PURPOSE
//  Receive side of the speed-select enable-pulse interface. Consumes the periodic one-cycle
//  enable pulse produced by the DIP-selected tick generator and measures the interval between
//  pulses. Decodes that interval back into the 2-bit speed code (dip2,dip1) with lock/error
//  status. Used for board self-check and to drive status LEDs from the pulse stream alone.
// PARAMETERS
//  CNT_W       27          period counter width
//  P0          80000001    expected period (cycles) for code 2'b00 (dip2=0,dip1=0)
//  P1          40000001    expected period for code 2'b01 (dip1=1)
//  P2          20000001    expected period for code 2'b10 (dip2=1)
//  P3          10000001    expected period for code 2'b11
//  TOL         16          accepted deviation, +/- cycles, inclusive
//  LOCK_COUNT  2           consecutive matching periods required to lock (>=1)
//  TIMEOUT     100000000   cycles without a tick before declaring no_tick (< 2**CNT_W)
// PORTS
//  clk         in   1      system clock
//  rst         in   1      reset; one clock; reset is synchronous and active-high
//  en_in       in   1      enable pulse from tick generator, clk domain, no synchroniser
//  spd_code    out  2      decoded code {dip2,dip1}; valid only while locked
//  locked      out  1      high while the decoded code is stable
//  period_err  out  1      one-cycle pulse: measured period broke lock or matched no code
//  no_tick     out  1      sticky: TIMEOUT cycles elapsed with no tick; cleared by next tick
//  period_cnt  out  CNT_W  last measured period in cycles
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, cnt=0, cand=0, run=0, en_d=0.
//  - Tick = en_in & ~en_d (rising edge; en_d is a register). A held-high en_in is one tick.
//  - Period counter cnt: loads 1 in a tick cycle and increments otherwise while not IDLE.
//    Saturates at TIMEOUT. Ticks at cycles t and t+P give cnt==P in the second tick cycle.
//    That cnt value is the measured period M and is written to period_cnt.
//  - Match k: P_k-TOL <= M <= P_k+TOL. Compare at CNT_W+1 bits so there is no underflow.
//    If ranges overlap, the lowest k wins.
//  - States: IDLE, MEASURE, LOCKED.
//    IDLE: tick -> MEASURE. cnt<=1, no_tick<=0. No measurement is made.
//    MEASURE, tick, match c:
//      If c==cand and run+1>=LOCK_COUNT: go LOCKED, spd_code<=c, locked<=1.
//      Otherwise: if c==cand then run<=run+1, else cand<=c and run<=1.
//    MEASURE, tick, no match: period_err=1, run<=0.
//    LOCKED, tick, match spd_code: stay LOCKED, no pulse.
//    LOCKED, tick, match other c: period_err=1, locked<=0, cand<=c, run<=1, go MEASURE.
//    LOCKED, tick, no match: period_err=1, locked<=0, run<=0, go MEASURE.
//  - Outputs change on the clock edge after the deciding tick (1-cycle latency from en_in).
//  - Timeout: in MEASURE or LOCKED with cnt==TIMEOUT and no tick -> no_tick<=1, locked<=0,
//    run<=0, go IDLE. period_err is not pulsed.
//  - A tick in the same cycle as cnt==TIMEOUT counts as a tick; timeout is ignored.
//  - spd_code holds its last value after lock loss. Consumers qualify it with locked.
//  - rst asserted mid-operation returns to the reset state at the next edge.
//    The first tick after reset is treated as the first tick ever.
// STRUCTURE
//  - Shared package: speed-code encodings (2'b00..2'b11), default periods P0..P3,
//    default TOL/TIMEOUT, state enum IDLE/MEASURE/LOCKED.
//    The same period constants are shared with the tick generator so both ends agree.
//  - One sub-module: speed_period_classifier. Combinational, inputs M, P0..P3, TOL;
//    outputs hit and code[1:0]. Instantiated once.
//  - Top holds the edge detector, period counter, FSM and output registers.
// TESTING (bench overrides P0=80,P1=40,P2=20,P3=10,TOL=2,LOCK_COUNT=2,TIMEOUT=120)
//  1. Ticks every 40 cycles x3 -> locked=1, spd_code=01 one cycle after the 3rd tick;
//     period_cnt=40; no period_err.
//  2. Locked on 10, then ticks every 20 -> first 20-cycle tick: period_err pulse,
//     locked=0; next 20-cycle tick: locked=1, spd_code=10.
//  3. Ticks every 81 and 79 (within TOL) -> locks code 00. A period of 83 -> period_err,
//     locked=0, MEASURE.
//  4. Locked, then en_in held 0 -> exactly 120 cycles after the last tick no_tick=1,
//     locked=0, state IDLE. Next tick clears no_tick and makes no measurement.
//  5. en_in held high 5 cycles, repeated every 20 -> counted as single ticks; locks code 10.
//  6. rst pulsed while locked -> all outputs 0 the next cycle. Relock needs 3 further ticks.

Source files
------------

// File: rtl/speed_tick_decoder_pkg.sv
// Shared constants for the speed-select enable-pulse link: code encodings,
// nominal periods per code, tolerance/timeout defaults and decoder states.
package speed_tick_decoder_pkg;

  typedef enum logic [1:0] {
    SPD_00 = 2'b00,
    SPD_01 = 2'b01,
    SPD_10 = 2'b10,
    SPD_11 = 2'b11
  } spd_code_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  localparam int unsigned DEF_CNT_W      = 27;
  localparam int unsigned DEF_P0         = 80000001;
  localparam int unsigned DEF_P1         = 40000001;
  localparam int unsigned DEF_P2         = 20000001;
  localparam int unsigned DEF_P3         = 10000001;
  localparam int unsigned DEF_TOL        = 16;
  localparam int unsigned DEF_LOCK_COUNT = 2;
  localparam int unsigned DEF_TIMEOUT    = 100000000;

endpackage

// File: rtl/speed_tick_decoder_if.sv
// Enable-pulse link: tick generator drives en_in, decoder returns code and status.
interface speed_tick_decoder_if
  import speed_tick_decoder_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) ();

  logic             en_in;
  logic [1:0]       spd_code;
  logic             locked;
  logic             period_err;
  logic             no_tick;
  logic [CNT_W-1:0] period_cnt;

  modport master (
    output en_in,
    input  spd_code, locked, period_err, no_tick, period_cnt
  );

  modport slave (
    input  en_in,
    output spd_code, locked, period_err, no_tick, period_cnt
  );

endinterface

// File: rtl/speed_period_classifier.sv
// Maps a measured period onto the speed code whose nominal period lies within
// +/- tolerance; the lowest matching code wins when windows overlap.
module speed_period_classifier
  import speed_tick_decoder_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic [CNT_W-1:0] i_m,
  input  logic [CNT_W-1:0] i_p0,
  input  logic [CNT_W-1:0] i_p1,
  input  logic [CNT_W-1:0] i_p2,
  input  logic [CNT_W-1:0] i_p3,
  input  logic [CNT_W-1:0] i_tol,
  output logic             o_hit_c,
  output logic [1:0]       o_code_c
);

  localparam int unsigned EW = CNT_W + 1;

  logic [EW-1:0] w_p [4];
  logic [EW-1:0] w_m;
  logic [EW-1:0] w_tol;

  assign w_m   = EW'(i_m);
  assign w_tol = EW'(i_tol);
  assign w_p[0] = EW'(i_p0);
  assign w_p[1] = EW'(i_p1);
  assign w_p[2] = EW'(i_p2);
  assign w_p[3] = EW'(i_p3);

  // Window test rearranged as m+tol >= p so nothing is subtracted.
  always_comb begin
    o_hit_c  = 1'b0;
    o_code_c = 2'b00;
    for (int k = 3; k >= 0; k--) begin
      if ((w_m + w_tol >= w_p[k]) && (w_m <= w_p[k] + w_tol)) begin
        o_hit_c  = 1'b1;
        o_code_c = 2'(k);
      end
    end
  end

endmodule

// File: rtl/speed_tick_decoder.sv
// Recovers the DIP speed code from the enable-pulse stream by timing the
// interval between rising edges and requiring repeated agreement before lock.
module speed_tick_decoder
  import speed_tick_decoder_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned P0         = DEF_P0,
  parameter int unsigned P1         = DEF_P1,
  parameter int unsigned P2         = DEF_P2,
  parameter int unsigned P3         = DEF_P3,
  parameter int unsigned TOL        = DEF_TOL,
  parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input logic                 clk,
  input logic                 rst,
  speed_tick_decoder_if.slave bus
);

  localparam int unsigned      RUN_W     = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e           r_state;
  logic             r_en_d;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_cand;
  logic [RUN_W-1:0] r_run;
  logic [1:0]       r_spd_code;
  logic             r_locked;
  logic             r_period_err;
  logic             r_no_tick;
  logic [CNT_W-1:0] r_period_cnt;

  logic             w_tick;
  logic             w_hit;
  logic [1:0]       w_code;
  logic [RUN_W:0]   w_run_inc;
  logic             w_lock_ok;
  logic             w_timeout;

  assign w_tick    = bus.en_in & ~r_en_d;
  assign w_run_inc = {1'b0, r_run} + (RUN_W + 1)'(1);
  assign w_lock_ok = (32'(w_run_inc) >= LOCK_COUNT);
  assign w_timeout = (r_cnt == TIMEOUT_C);

  speed_period_classifier #(.CNT_W(CNT_W)) u_classifier (
    .i_m      (r_cnt),
    .i_p0     (CNT_W'(P0)),
    .i_p1     (CNT_W'(P1)),
    .i_p2     (CNT_W'(P2)),
    .i_p3     (CNT_W'(P3)),
    .i_tol    (CNT_W'(TOL)),
    .o_hit_c  (w_hit),
    .o_code_c (w_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_en_d       <= 1'b0;
      r_cnt        <= '0;
      r_cand       <= 2'b00;
      r_run        <= '0;
      r_spd_code   <= 2'b00;
      r_locked     <= 1'b0;
      r_period_err <= 1'b0;
      r_no_tick    <= 1'b0;
      r_period_cnt <= '0;
    end else begin
      r_en_d       <= bus.en_in;
      r_period_err <= 1'b0;

      // Period counter restarts on every tick and parks at the timeout value.
      if (w_tick) begin
        r_cnt     <= CNT_W'(1);
        r_no_tick <= 1'b0;
      end else if ((r_state != ST_IDLE) && !w_timeout) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_tick && (r_state != ST_IDLE)) begin
        r_period_cnt <= r_cnt;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            r_state <= ST_MEASURE;
          end
        end

        ST_MEASURE: begin
          if (w_tick) begin
            if (!w_hit) begin
              r_period_err <= 1'b1;
              r_run        <= '0;
            end else if ((w_code == r_cand) && w_lock_ok) begin
              r_state    <= ST_LOCKED;
              r_spd_code <= w_code;
              r_locked   <= 1'b1;
            end else if (w_code == r_cand) begin
              r_run <= r_run + RUN_W'(1);
            end else begin
              r_cand <= w_code;
              r_run  <= RUN_W'(1);
            end
          end else if (w_timeout) begin
            r_state   <= ST_IDLE;
            r_no_tick <= 1'b1;
            r_locked  <= 1'b0;
            r_run     <= '0;
          end
        end

        ST_LOCKED: begin
          if (w_tick) begin
            // A different code restarts qualification with one vote already in hand.
            if (!(w_hit && (w_code == r_spd_code))) begin
              r_state      <= ST_MEASURE;
              r_period_err <= 1'b1;
              r_locked     <= 1'b0;
              if (w_hit) begin
                r_cand <= w_code;
                r_run  <= RUN_W'(1);
              end else begin
                r_run <= '0;
              end
            end
          end else if (w_timeout) begin
            r_state   <= ST_IDLE;
            r_no_tick <= 1'b1;
            r_locked  <= 1'b0;
            r_run     <= '0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.spd_code   = r_spd_code;
  assign bus.locked     = r_locked;
  assign bus.period_err = r_period_err;
  assign bus.no_tick    = r_no_tick;
  assign bus.period_cnt = r_period_cnt;

endmodule

// File: tb/tb_speed_tick_decoder.sv
// Bench for speed_tick_decoder: directed vector table, corner-case sequences and
// random pulse trains, all checked against a cycle-level behavioural model.
module tb_speed_tick_decoder;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned P0    = 80;
  localparam int unsigned P1    = 40;
  localparam int unsigned P2    = 20;
  localparam int unsigned P3    = 10;
  localparam int unsigned TOL   = 2;
  localparam int unsigned LOCK  = 2;
  localparam int unsigned TMO   = 120;

  logic clk = 1'b0;
  logic rst = 1'b1;

  speed_tick_decoder_if #(.CNT_W(CNT_W)) tif ();

  speed_tick_decoder #(
    .CNT_W(CNT_W), .P0(P0), .P1(P1), .P2(P2), .P3(P3),
    .TOL(TOL), .LOCK_COUNT(LOCK), .TIMEOUT(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int err_seen = 0;

  // Behavioural model: time measured as difference of absolute edge numbers.
  int cyc = 0;
  int m_en_d = 0, m_active = 0, m_last = 0, m_cand = 0, m_streak = 0;
  int e_locked = 0, e_code = 0, e_err = 0, e_nt = 0, e_pcnt = 0;

  function automatic int classify(input int m);
    int prd [4];
    prd = '{int'(P0), int'(P1), int'(P2), int'(P3)};
    for (int k = 0; k < 4; k++) begin
      if (m - prd[k] <= int'(TOL) && prd[k] - m <= int'(TOL)) return k;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int tick, mm, k;
    cyc++;
    if (rst) begin
      m_en_d = 0; m_active = 0; m_last = 0; m_cand = 0; m_streak = 0;
      e_locked = 0; e_code = 0; e_err = 0; e_nt = 0; e_pcnt = 0;
    end else begin
      tick   = (tif.en_in === 1'b1 && m_en_d == 0) ? 1 : 0;
      m_en_d = (tif.en_in === 1'b1) ? 1 : 0;
      e_err  = 0;
      if (m_active == 0) begin
        if (tick != 0) begin
          m_active = 1; m_last = cyc; e_nt = 0;
        end
      end else if (tick != 0) begin
        mm = cyc - m_last; m_last = cyc; e_pcnt = mm;
        k  = classify(mm);
        if (e_locked != 0) begin
          if (k != e_code) begin
            e_err = 1; e_locked = 0;
            if (k >= 0) begin m_cand = k; m_streak = 1; end
            else m_streak = 0;
          end
        end else if (k < 0) begin
          e_err = 1; m_streak = 0;
        end else if (k == m_cand && m_streak + 1 >= int'(LOCK)) begin
          e_locked = 1; e_code = k;
        end else if (k == m_cand) begin
          m_streak++;
        end else begin
          m_cand = k; m_streak = 1;
        end
      end else if (cyc - m_last >= int'(TMO)) begin
        e_nt = 1; e_locked = 0; m_streak = 0; m_active = 0;
      end
    end
  end

  always @(negedge clk) begin
    n_checks++;
    if (tif.locked !== 1'(e_locked) || tif.spd_code !== 2'(e_code) ||
        tif.period_err !== 1'(e_err) || tif.no_tick !== 1'(e_nt) ||
        tif.period_cnt !== CNT_W'(e_pcnt)) begin
      n_errs++;
      $display("FAIL model_cycle%0d got lk=%b cd=%b er=%b nt=%b pc=%0d want lk=%0d cd=%0d er=%0d nt=%0d pc=%0d",
               cyc, tif.locked, tif.spd_code, tif.period_err, tif.no_tick, tif.period_cnt,
               e_locked, e_code, e_err, e_nt, e_pcnt);
    end
    if (tif.period_err === 1'b1) err_seen++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic step(input logic v);
    @(posedge clk);
    #1 tif.en_in = v;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1; tif.en_in = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Tick lands on the next edge; returns at the negedge right after it.
  task automatic first_tick();
    step(1'b1);
    step(1'b0);
    @(negedge clk);
  endtask

  task automatic tick_after(input int p);
    repeat (p - 2) step(1'b0);
    step(1'b1);
    step(1'b0);
    @(negedge clk);
  endtask

  task automatic send_ticks(input int p, input int n);
    first_tick();
    repeat (n - 1) tick_after(p);
  endtask

  typedef struct {
    int         period;
    int         nticks;
    logic       locked;
    logic [1:0] code;
    int         pcnt;
    int         errs;
    logic       nt;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, w, rep, e0;
    vecs[0]  = '{40,  3, 1'b1, 2'b01, 40,  0, 1'b0};
    vecs[1]  = '{20,  2, 1'b0, 2'b00, 20,  0, 1'b0};
    vecs[2]  = '{10,  4, 1'b1, 2'b11, 10,  0, 1'b0};
    vecs[3]  = '{83,  3, 1'b0, 2'b00, 83,  2, 1'b0};
    vecs[4]  = '{82,  3, 1'b1, 2'b00, 82,  0, 1'b0};
    vecs[5]  = '{78,  3, 1'b1, 2'b00, 78,  0, 1'b0};
    vecs[6]  = '{38,  3, 1'b1, 2'b01, 38,  0, 1'b0};
    vecs[7]  = '{23,  3, 1'b0, 2'b00, 23,  2, 1'b0};
    vecs[8]  = '{12,  3, 1'b1, 2'b11, 12,  0, 1'b0};
    vecs[9]  = '{120, 3, 1'b0, 2'b00, 120, 2, 1'b0};
    vecs[10] = '{121, 3, 1'b0, 2'b00, 0,   0, 1'b0};

    tif.en_in = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_locked", 32'(tif.locked), 0);
    check("rst_code", 32'(tif.spd_code), 0);
    check("rst_err", 32'(tif.period_err), 0);
    check("rst_notick", 32'(tif.no_tick), 0);
    check("rst_pcnt", 32'(tif.period_cnt), 0);

    for (int i = 0; i < 11; i++) begin
      do_reset();
      err_seen = 0;
      send_ticks(vecs[i].period, vecs[i].nticks);
      #1;
      check($sformatf("vec%0d_locked", i), 32'(tif.locked), 32'(vecs[i].locked));
      check($sformatf("vec%0d_code", i), 32'(tif.spd_code), 32'(vecs[i].code));
      check($sformatf("vec%0d_pcnt", i), 32'(tif.period_cnt), vecs[i].pcnt);
      check($sformatf("vec%0d_errs", i), err_seen, vecs[i].errs);
      check($sformatf("vec%0d_notick", i), 32'(tif.no_tick), 32'(vecs[i].nt));
    end

    // Locked on code 11, then the generator switches to code 10.
    do_reset();
    send_ticks(10, 3);
    check("sw_lock11", 32'({tif.locked, tif.spd_code}), 32'(3'b111));
    tick_after(20);
    check("sw_err", 32'(tif.period_err), 1);
    check("sw_unlock", 32'(tif.locked), 0);
    tick_after(20);
    check("sw_lock10", 32'({tif.locked, tif.spd_code}), 32'(3'b110));

    // Jitter within tolerance locks; a period just outside breaks lock.
    do_reset();
    first_tick();
    tick_after(81);
    tick_after(79);
    check("jit_lock00", 32'({tif.locked, tif.spd_code}), 32'(3'b100));
    tick_after(83);
    check("jit_err", 32'(tif.period_err), 1);
    check("jit_unlock", 32'(tif.locked), 0);

    // Timeout lands exactly TMO edges after the last tick.
    do_reset();
    send_ticks(40, 3);
    repeat (119) step(1'b0);
    @(negedge clk);
    check("tmo_before_nt", 32'(tif.no_tick), 0);
    check("tmo_before_lk", 32'(tif.locked), 1);
    step(1'b0);
    @(negedge clk);
    check("tmo_nt", 32'(tif.no_tick), 1);
    check("tmo_lk", 32'(tif.locked), 0);
    check("tmo_err", 32'(tif.period_err), 0);
    e0 = err_seen;
    first_tick();
    #1;
    check("tmo_clear_nt", 32'(tif.no_tick), 0);
    check("tmo_no_meas", 32'(tif.period_cnt), 40);
    check("tmo_no_err", err_seen - e0, 0);

    // Wide enable pulses count once per rising edge.
    do_reset();
    err_seen = 0;
    for (int g = 0; g < 3; g++) begin
      repeat (5) step(1'b1);
      repeat (15) step(1'b0);
    end
    @(negedge clk);
    #1;
    check("wide_lock10", 32'({tif.locked, tif.spd_code}), 32'(3'b110));
    check("wide_pcnt", 32'(tif.period_cnt), 20);
    check("wide_errs", err_seen, 0);

    // Reset while locked; relock needs three fresh ticks.
    do_reset();
    send_ticks(20, 3);
    check("rl_locked", 32'(tif.locked), 1);
    do_reset();
    @(negedge clk);
    check("rl_rst_all", 32'({tif.locked, tif.spd_code, tif.period_err, tif.no_tick, tif.period_cnt}), 0);
    send_ticks(20, 2);
    check("rl_two_ticks", 32'(tif.locked), 0);
    tick_after(20);
    check("rl_three_ticks", 32'({tif.locked, tif.spd_code}), 32'(3'b110));

    // Random pulse trains; the model checks every cycle.
    do_reset();
    for (int r = 0; r < 60; r++) begin
      if ($urandom_range(0, 14) == 0) do_reset();
      case ($urandom_range(0, 3))
        0, 1:    p = int'(P3) * (1 << $urandom_range(0, 3)) + int'($urandom_range(0, 6)) - 3;
        2:       p = int'($urandom_range(2, 130));
        default: p = int'(P3) * (1 << $urandom_range(0, 3)) + int'($urandom_range(0, 4)) - 2;
      endcase
      w = int'($urandom_range(1, (p - 1 < 3) ? p - 1 : 3));
      rep = int'($urandom_range(1, 4));
      repeat (rep) begin
        repeat (w) step(1'b1);
        repeat (p - w) step(1'b0);
      end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
